// File: rtl/nibble_control_unit.sv
// nibble_control_unit: fetch/decode/sequencing stage for the 4-bit nibble ALU (optional SINGLE_STEP_EN adds a step input gating FETCH)
module nibble_control_unit #(
  parameter logic [11:0] RESET_VECTOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [11:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [3:0]  data_in,
  output logic [2:0]  alu_f,
  output logic [3:0]  alu_b,
  input  logic        alu_c_out,
  input  logic        alu_zero,
  output logic        acc_we,
  output logic        out_we,
  output logic        flag_c,
  output logic        flag_z,
  output logic        halted
);
  typedef enum logic [2:0] {FETCH, DECODE, OPERAND, EXECUTE, HALT} state_t;
  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  addr_lo_q, addr_lo_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;
  logic [3:0]  op, imm;
  logic        fetch_go, exec, alu_op, carry_op, is_jump, taken;
  assign op  = ir_q[7:4];
  assign imm = ir_q[3:0];
`ifdef SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif
  // ops 0-7 go through the ALU; 0,1,4,5 also produce a meaningful carry
  assign alu_op   = !op[3];
  assign carry_op = !op[3] && !op[1];
  assign is_jump  = (op >= 4'h9) && (op <= 4'hD);
  assign taken    = (op == 4'h9 && flag_c_q) || (op == 4'hA && !flag_c_q) ||
                    (op == 4'hB && flag_z_q) || (op == 4'hC && !flag_z_q) || (op == 4'hD);
  // a reset arriving in EXECUTE must kill that cycle's strobes combinationally
  assign exec = (state_q == EXECUTE) && !reset;
  assign prog_addr = pc_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign halted    = (state_q == HALT);
  // sequencing: PC, IR, jump low byte, flags and next state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    addr_lo_d = addr_lo_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    case (state_q)
      FETCH: begin
        if (fetch_go) begin
          ir_d    = prog_data;
          pc_d    = pc_q + 12'd1;
          state_d = DECODE;
        end
      end
      DECODE:  state_d = is_jump ? OPERAND : (op == 4'hF ? HALT : EXECUTE);
      OPERAND: begin
        addr_lo_d = prog_data;
        pc_d      = pc_q + 12'd1;
        state_d   = EXECUTE;
      end
      EXECUTE: begin
        flag_c_d = carry_op ? alu_c_out : flag_c_q;
        flag_z_d = alu_op ? alu_zero : flag_z_q;
        pc_d     = (is_jump && taken) ? {imm, addr_lo_q} : pc_q;
        state_d  = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  // ALU function, operand and write strobes, only live in EXECUTE
  always_comb begin
    alu_f  = 3'b000;
    alu_b  = 4'd0;
    acc_we = 1'b0;
    out_we = 1'b0;
    if (exec) begin
      alu_f  = alu_op ? {1'b0, op[2:1]} + 3'd1 : 3'b000;
      alu_b  = alu_op ? (op[0] ? data_in : imm) : 4'd0;
      acc_we = alu_op && (op[2:1] != 2'b00);
      out_we = (op == 4'h8);
    end
  end
  // state register with synchronous reset taking priority everywhere
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VECTOR;
      ir_q      <= 8'd0;
      addr_lo_q <= 8'd0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      addr_lo_q <= addr_lo_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
    end
  end
endmodule

// File: tb/tb_nibble_control_unit.sv
// tb_nibble_control_unit: directed checks of the nibble control unit against a bench ALU/accumulator model
module tb_nibble_control_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rom [4096];
  logic [11:0] prog_addr, prog_addr2;
  logic [7:0]  prog_data, prog_data2;
  logic [3:0]  data_in = 4'h6;
  logic [2:0]  alu_f, alu_f2;
  logic [3:0]  alu_b, alu_b2;
  logic        alu_c, alu_zero;
  logic [3:0]  alu_y, acc;
  logic        acc_we, out_we, flag_c, flag_z, halted;
  logic        acc_we2, out_we2, flag_c2, flag_z2, halted2;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  assign prog_data  = rom[prog_addr];
  assign prog_data2 = rom[prog_addr2];

  nibble_control_unit dut (
    .clk(clk), .reset(reset),
`ifdef SINGLE_STEP_EN
    .step(1'b1),
`endif
    .prog_addr(prog_addr), .prog_data(prog_data), .data_in(data_in),
    .alu_f(alu_f), .alu_b(alu_b), .alu_c_out(alu_c), .alu_zero(alu_zero),
    .acc_we(acc_we), .out_we(out_we), .flag_c(flag_c), .flag_z(flag_z), .halted(halted)
  );

  nibble_control_unit #(.RESET_VECTOR(12'hFFF)) dut_v (
    .clk(clk), .reset(reset),
`ifdef SINGLE_STEP_EN
    .step(1'b1),
`endif
    .prog_addr(prog_addr2), .prog_data(prog_data2), .data_in(data_in),
    .alu_f(alu_f2), .alu_b(alu_b2), .alu_c_out(1'b0), .alu_zero(1'b0),
    .acc_we(acc_we2), .out_we(out_we2), .flag_c(flag_c2), .flag_z(flag_z2), .halted(halted2)
  );

  always_comb begin
    {alu_c, alu_y} = {1'b0, acc};
    case (alu_f)
      3'b001:  {alu_c, alu_y} = {1'b0, acc} - {1'b0, alu_b};
      3'b010:  {alu_c, alu_y} = {1'b0, alu_b};
      3'b011:  {alu_c, alu_y} = {1'b0, acc} + {1'b0, alu_b};
      3'b100:  {alu_c, alu_y} = {1'b0, ~(acc | alu_b)};
      default: {alu_c, alu_y} = {1'b0, acc};
    endcase
    alu_zero = (alu_y == 4'd0);
  end

  always @(posedge clk) begin
    if (reset) acc <= 4'd0;
    else if (acc_we) acc <= alu_y;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'hE0;
  endtask

  // leaves the bench observing cycle 1 (first FETCH) after reset release
  task automatic start();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    reset = 1'b1;
    cyc(2);
    n_checks += 9;
    if (prog_addr !== 12'h000) begin n_fail++; $display("FAIL rst_pc got %h want 000", prog_addr); end
    if (prog_addr2 !== 12'hFFF) begin n_fail++; $display("FAIL rst_pc_vec got %h want fff", prog_addr2); end
    if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b want 0", halted); end
    if (acc_we !== 1'b0) begin n_fail++; $display("FAIL rst_acc_we got %b want 0", acc_we); end
    if (out_we !== 1'b0) begin n_fail++; $display("FAIL rst_out_we got %b want 0", out_we); end
    if (alu_f !== 3'b000) begin n_fail++; $display("FAIL rst_alu_f got %b want 000", alu_f); end
    if (alu_b !== 4'h0) begin n_fail++; $display("FAIL rst_alu_b got %h want 0", alu_b); end
    if (flag_c !== 1'b0) begin n_fail++; $display("FAIL rst_flag_c got %b want 0", flag_c); end
    if (flag_z !== 1'b0) begin n_fail++; $display("FAIL rst_flag_z got %b want 0", flag_z); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_rom();
    rom[0] = 8'h25; rom[1] = 8'h43; rom[2] = 8'h80;
    start();
    cyc(2);
    n_checks += 4;
    if (acc_we !== 1'b1) begin n_fail++; $display("FAIL lit_acc_we got %b want 1", acc_we); end
    if (alu_f !== 3'b010) begin n_fail++; $display("FAIL lit_alu_f got %b want 010", alu_f); end
    if (alu_b !== 4'h5) begin n_fail++; $display("FAIL lit_alu_b got %h want 5", alu_b); end
    if (prog_addr !== 12'h001) begin n_fail++; $display("FAIL lit_pc got %h want 001", prog_addr); end
    cyc(3);
    n_checks += 3;
    if (acc_we !== 1'b1) begin n_fail++; $display("FAIL addi_acc_we got %b want 1", acc_we); end
    if (alu_f !== 3'b011) begin n_fail++; $display("FAIL addi_alu_f got %b want 011", alu_f); end
    if (alu_b !== 4'h3) begin n_fail++; $display("FAIL addi_alu_b got %h want 3", alu_b); end
    cyc(3);
    n_checks += 6;
    if (out_we !== 1'b1) begin n_fail++; $display("FAIL out_out_we got %b want 1", out_we); end
    if (acc_we !== 1'b0) begin n_fail++; $display("FAIL out_acc_we got %b want 0", acc_we); end
    if (alu_f !== 3'b000) begin n_fail++; $display("FAIL out_alu_f got %b want 000", alu_f); end
    if (flag_c !== 1'b0) begin n_fail++; $display("FAIL basic_flag_c got %b want 0", flag_c); end
    if (flag_z !== 1'b0) begin n_fail++; $display("FAIL basic_flag_z got %b want 0", flag_z); end
    if (acc !== 4'h8) begin n_fail++; $display("FAIL basic_acc got %h want 8", acc); end
    cyc(1);
    n_checks += 1;
    if (out_we !== 1'b0) begin n_fail++; $display("FAIL out_pulse_len got %b want 0", out_we); end
  endtask

  task automatic test_mem_ops();
    clear_rom();
    rom[0] = 8'h30; rom[1] = 8'h50; rom[2] = 8'h0C; rom[3] = 8'h70;
    start();
    cyc(2);
    n_checks += 2;
    if (alu_f !== 3'b010) begin n_fail++; $display("FAIL in_alu_f got %b want 010", alu_f); end
    if (alu_b !== 4'h6) begin n_fail++; $display("FAIL in_alu_b got %h want 6", alu_b); end
    cyc(3);
    n_checks += 2;
    if (alu_f !== 3'b011) begin n_fail++; $display("FAIL addm_alu_f got %b want 011", alu_f); end
    if (alu_b !== 4'h6) begin n_fail++; $display("FAIL addm_alu_b got %h want 6", alu_b); end
    cyc(3);
    n_checks += 3;
    if (alu_f !== 3'b001) begin n_fail++; $display("FAIL cmpi_alu_f got %b want 001", alu_f); end
    if (alu_b !== 4'hC) begin n_fail++; $display("FAIL cmpi_alu_b got %h want c", alu_b); end
    if (acc_we !== 1'b0) begin n_fail++; $display("FAIL cmpi_acc_we got %b want 0", acc_we); end
    cyc(1);
    n_checks += 2;
    if (flag_z !== 1'b1) begin n_fail++; $display("FAIL cmpi_flag_z got %b want 1", flag_z); end
    if (flag_c !== 1'b0) begin n_fail++; $display("FAIL cmpi_flag_c got %b want 0", flag_c); end
    cyc(2);
    n_checks += 2;
    if (alu_f !== 3'b100) begin n_fail++; $display("FAIL norm_alu_f got %b want 100", alu_f); end
    if (alu_b !== 4'h6) begin n_fail++; $display("FAIL norm_alu_b got %h want 6", alu_b); end
    cyc(1);
    n_checks += 2;
    if (acc !== 4'h1) begin n_fail++; $display("FAIL norm_acc got %h want 1", acc); end
    if (flag_z !== 1'b0) begin n_fail++; $display("FAIL norm_flag_z got %b want 0", flag_z); end
  endtask

  task automatic test_flags();
    clear_rom();
    rom[0] = 8'h2F; rom[1] = 8'h41;
    start();
    cyc(6);
    n_checks += 3;
    if (flag_c !== 1'b1) begin n_fail++; $display("FAIL carry_flag_c got %b want 1", flag_c); end
    if (flag_z !== 1'b1) begin n_fail++; $display("FAIL carry_flag_z got %b want 1", flag_z); end
    if (acc !== 4'h0) begin n_fail++; $display("FAIL carry_acc got %h want 0", acc); end
  endtask

  task automatic test_jumps();
    clear_rom();
    rom[0] = 8'h2F; rom[1] = 8'h41; rom[2] = 8'hB1; rom[3] = 8'h23;
    start();
    cyc(8);
    n_checks += 2;
    if (prog_addr !== 12'h003) begin n_fail++; $display("FAIL jz_operand_pc got %h want 003", prog_addr); end
    if (alu_f !== 3'b000) begin n_fail++; $display("FAIL jz_operand_alu_f got %b want 000", alu_f); end
    cyc(1);
    n_checks += 1;
    if (acc_we !== 1'b0) begin n_fail++; $display("FAIL jz_exec_acc_we got %b want 0", acc_we); end
    cyc(1);
    n_checks += 1;
    if (prog_addr !== 12'h123) begin n_fail++; $display("FAIL jz_taken_pc got %h want 123", prog_addr); end
    rom[2] = 8'hC1;
    start();
    cyc(10);
    n_checks += 1;
    if (prog_addr !== 12'h004) begin n_fail++; $display("FAIL jnz_not_taken_pc got %h want 004", prog_addr); end
    clear_rom();
    rom[0] = 8'hD0; rom[1] = 8'h10;
    start();
    cyc(4);
    n_checks += 1;
    if (prog_addr !== 12'h010) begin n_fail++; $display("FAIL jmp_pc got %h want 010", prog_addr); end
  endtask

  task automatic test_wrap();
    clear_rom();
    start();
    n_checks += 1;
    if (prog_addr2 !== 12'hFFF) begin n_fail++; $display("FAIL wrap_start_pc got %h want fff", prog_addr2); end
    cyc(2);
    n_checks += 1;
    if (acc_we2 !== 1'b0) begin n_fail++; $display("FAIL wrap_nop_acc_we got %b want 0", acc_we2); end
    cyc(1);
    n_checks += 1;
    if (prog_addr2 !== 12'h000) begin n_fail++; $display("FAIL wrap_pc got %h want 000", prog_addr2); end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 8'hF0;
    start();
    cyc(2);
    for (int i = 0; i < 20; i++) begin
      n_checks += 3;
      if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag cyc %0d got %b want 1", i, halted); end
      if (prog_addr !== 12'h001) begin n_fail++; $display("FAIL halt_pc cyc %0d got %h want 001", i, prog_addr); end
      if ({acc_we, out_we} !== 2'b00) begin n_fail++; $display("FAIL halt_we cyc %0d got %b want 00", i, {acc_we, out_we}); end
      cyc(1);
    end
    reset = 1'b1;
    cyc(1);
    n_checks += 2;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_exit got %b want 0", halted); end
    if (prog_addr !== 12'h000) begin n_fail++; $display("FAIL halt_exit_pc got %h want 000", prog_addr); end
    reset = 1'b0;
  endtask

  task automatic test_reset_in_execute();
    clear_rom();
    rom[0] = 8'h2F; rom[1] = 8'h41;
    start();
    cyc(5);
    n_checks += 1;
    if (acc_we !== 1'b1) begin n_fail++; $display("FAIL rexec_pre_acc_we got %b want 1", acc_we); end
    reset = 1'b1;
    #1;
    n_checks += 1;
    if (acc_we !== 1'b0) begin n_fail++; $display("FAIL rexec_acc_we got %b want 0", acc_we); end
    cyc(1);
    n_checks += 3;
    if (flag_c !== 1'b0) begin n_fail++; $display("FAIL rexec_flag_c got %b want 0", flag_c); end
    if (flag_z !== 1'b0) begin n_fail++; $display("FAIL rexec_flag_z got %b want 0", flag_z); end
    if (prog_addr !== 12'h000) begin n_fail++; $display("FAIL rexec_pc got %h want 000", prog_addr); end
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_ops();
    test_flags();
    test_jumps();
    test_wrap();
    test_halt();
    test_reset_in_execute();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
